// File: rtl/lsu_pkg.sv
// Shared load/store definitions: funct3 encodings, FSM states, byte-lane count
// and the funct3 legality helper used by the request decoder.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LANES = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        RD_WAIT = 3'd3,
        RESP    = 3'd4
    } state_t;

    // Stores only have B/H/W; loads add the unsigned byte/halfword forms.
    function automatic logic f_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we)
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: request error decode, store replication/masking,
// load lane extraction with sign or zero extension. No state, no latency.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [1:0]        i_req_addr_lo,
    output logic              o_req_err,
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_addr_lo,
    input  logic [DW-1:0]     i_wdata,
    input  logic [DW-1:0]     i_rdata,
    output logic [DW-1:0]     o_wd,
    output logic [LANES-1:0]  o_wmask,
    output logic [DW-1:0]     o_ldata
);

    logic        w_misal;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Error decode runs on the live request so the FSM can branch at handshake.
    always_comb begin
        w_misal = 1'b0;
        case (i_req_funct3)
            F3_H, F3_HU: w_misal = i_req_addr_lo[0];
            F3_W:        w_misal = |i_req_addr_lo;
            default:     w_misal = 1'b0;
        endcase
        o_req_err = !f_legal(i_req_we, i_req_funct3) || w_misal;
    end

    always_comb begin
        o_wd    = i_wdata;
        o_wmask = 4'b1111;
        case (i_funct3[1:0])
            2'b00: begin
                o_wd    = {4{i_wdata[7:0]}};
                o_wmask = 4'b0001 << i_addr_lo;
            end
            2'b01: begin
                o_wd    = {2{i_wdata[15:0]}};
                o_wmask = 4'b0011 << i_addr_lo;
            end
            default: begin
                o_wd    = i_wdata;
                o_wmask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_byte  = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_ldata = i_rdata;
        case (i_funct3)
            F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
            F3_BU:   o_ldata = {24'd0, w_byte};
            F3_HU:   o_ldata = {16'd0, w_half};
            default: o_ldata = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: store rsp at T+2, load rsp at T+3, error rsp at T+1.
// One access in flight; req_ready only in IDLE, rsp_valid is an unbackpressured pulse.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic [AW-1:0]     mem_a,
    output logic [DW-1:0]     mem_wd,
    output logic              mem_we,
    output logic [LANES-1:0]  mem_wmask,
    output logic              mem_rstrb,
    input  logic [DW-1:0]     mem_rd
);

    state_t              r_state;
    state_t              w_next;
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata;
    logic [DW-1:0]       r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_hs;
    logic                w_req_err;
    logic [DW-1:0]       w_wd;
    logic [LANES-1:0]    w_wmask;
    logic [DW-1:0]       w_ldata;

    lsu_align #(.DW(DW)) u_align (
        .i_req_we      (req_we),
        .i_req_funct3  (req_funct3),
        .i_req_addr_lo (req_addr[1:0]),
        .o_req_err     (w_req_err),
        .i_funct3      (r_funct3),
        .i_addr_lo     (r_addr[1:0]),
        .i_wdata       (r_wdata),
        .i_rdata       (mem_rd),
        .o_wd          (w_wd),
        .o_wmask       (w_wmask),
        .o_ldata       (w_ldata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            // Response registers only change on the way into RESP.
            if (w_hs && w_req_err) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end else if (r_state == WRITE) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b0;
            end else if (r_state == RD_WAIT) begin
                r_rsp_rdata <= w_ldata;
                r_rsp_err   <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_we    = 1'b0;
        mem_rstrb = 1'b0;
        mem_wmask = '0;
        w_hs      = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = !reset;
                w_hs      = req_valid && !reset;
                if (w_hs) begin
                    if (w_req_err)
                        w_next = RESP;
                    else if (req_we)
                        w_next = WRITE;
                    else
                        w_next = READ;
                end
            end
            WRITE: begin
                // Gating with reset keeps an aborted store off the memory.
                mem_we    = r_we && !reset;
                mem_wmask = reset ? '0 : w_wmask;
                w_next    = RESP;
            end
            READ: begin
                mem_rstrb = !reset;
                w_next    = RD_WAIT;
            end
            RD_WAIT: w_next = RESP;
            RESP: begin
                rsp_valid = !reset;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = rsp_valid && r_rsp_err;
    assign mem_a     = {r_addr[AW-1:2], 2'b00};
    assign mem_wd    = w_wd;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a registered-read byte-maskable memory model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    lsu_ctrl #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_wmask  (mem_wmask),
        .mem_rstrb  (mem_rstrb),
        .mem_rd     (mem_rd)
    );

    logic [31:0] tmem [0:255];
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) tmem[i] <= 32'h0;
            tmem[8] <= 32'hCAFEF00D;
            mem_rd  <= 32'h0;
        end else begin
            if (mem_rstrb) mem_rd <= tmem[mem_a[9:2]];
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) tmem[mem_a[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    int          n_we, n_rs, n_rsp, we_cyc, rs_cyc, rsp_cyc;
    logic [3:0]  c_mask;
    logic [31:0] c_wd, c_a, c_rdata;
    logic        c_err;

    // Issue one request and record what happens over the next six cycles.
    task automatic access(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        check("rdy_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_we = 0; n_rs = 0; n_rsp = 0; we_cyc = 0; rs_cyc = 0; rsp_cyc = 0;
        c_mask = 4'h0; c_wd = 32'h0; c_a = 32'h0; c_rdata = 32'h0; c_err = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_we) begin
                n_we++; we_cyc = k; c_mask = mem_wmask; c_wd = mem_wd; c_a = mem_a;
            end
            if (mem_rstrb) begin n_rs++; rs_cyc = k; end
            if (rsp_valid) begin
                n_rsp++;
                if (rsp_cyc == 0) begin rsp_cyc = k; c_err = rsp_err; c_rdata = rsp_rdata; end
            end
        end
    endtask

    task automatic expect_store(input string tag, input logic [3:0] mask,
                                input logic [31:0] wd, input logic [31:0] a);
        check({tag, "_we_cyc"}, 32'(we_cyc), 32'd1);
        check({tag, "_we_cnt"}, 32'(n_we), 32'd1);
        check({tag, "_mask"}, 32'(c_mask), 32'(mask));
        check({tag, "_wd"}, c_wd, wd);
        check({tag, "_a"}, c_a, a);
        check({tag, "_rsp_cyc"}, 32'(rsp_cyc), 32'd2);
        check({tag, "_rsp_cnt"}, 32'(n_rsp), 32'd1);
        check({tag, "_err"}, 32'(c_err), 32'd0);
        check({tag, "_rdata"}, c_rdata, 32'd0);
    endtask

    task automatic expect_load(input string tag, input logic [31:0] rdata);
        check({tag, "_rs_cyc"}, 32'(rs_cyc), 32'd1);
        check({tag, "_rs_cnt"}, 32'(n_rs), 32'd1);
        check({tag, "_we_cnt"}, 32'(n_we), 32'd0);
        check({tag, "_rsp_cyc"}, 32'(rsp_cyc), 32'd3);
        check({tag, "_rsp_cnt"}, 32'(n_rsp), 32'd1);
        check({tag, "_err"}, 32'(c_err), 32'd0);
        check({tag, "_rdata"}, c_rdata, rdata);
    endtask

    task automatic expect_err(input string tag);
        check({tag, "_rsp_cyc"}, 32'(rsp_cyc), 32'd1);
        check({tag, "_rsp_cnt"}, 32'(n_rsp), 32'd1);
        check({tag, "_err"}, 32'(c_err), 32'd1);
        check({tag, "_rdata"}, c_rdata, 32'd0);
        check({tag, "_we_cnt"}, 32'(n_we), 32'd0);
        check({tag, "_rs_cnt"}, 32'(n_rs), 32'd0);
    endtask

    int bad_we, bad_rsp;

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_rst_ready", 32'(req_ready), 32'd0);
        check("in_rst_rsp", 32'(rsp_valid), 32'd0);
        check("in_rst_we", 32'(mem_we), 32'd0);
        check("in_rst_rstrb", 32'(mem_rstrb), 32'd0);
        check("in_rst_a", mem_a, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0; mem_init = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_mask", 32'(mem_wmask), 32'd0);
        check("post_rst_rdata", rsp_rdata, 32'h0);
        check("post_rst_err", 32'(rsp_err), 32'd0);

        access(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
        expect_store("sw10", 4'b1111, 32'hDEADBEEF, 32'h10);

        access(1'b1, F3_B, 32'h13, 32'h000000A5);
        expect_store("sb13", 4'b1000, 32'hA5A5A5A5, 32'h10);
        access(1'b0, F3_W, 32'h10, 32'h0);
        expect_load("lw10", 32'hA5ADBEEF);

        access(1'b0, F3_B, 32'h13, 32'h0);
        expect_load("lb13", 32'hFFFFFFA5);
        access(1'b0, F3_BU, 32'h13, 32'h0);
        expect_load("lbu13", 32'h000000A5);
        access(1'b0, F3_HU, 32'h12, 32'h0);
        expect_load("lhu12", 32'h0000A5AD);
        access(1'b0, F3_H, 32'h12, 32'h0);
        expect_load("lh12", 32'hFFFFA5AD);
        access(1'b0, F3_B, 32'h10, 32'h0);
        expect_load("lb10", 32'hFFFFFFEF);

        access(1'b1, F3_H, 32'h11, 32'h00001234);
        expect_err("sh11_mis");
        access(1'b0, F3_W, 32'h12, 32'h0);
        expect_err("lw12_mis");
        check("mem10_unchanged", tmem[4], 32'hA5ADBEEF);

        access(1'b0, 3'd3, 32'h10, 32'h0);
        expect_err("ld_f3_3");
        access(1'b1, 3'd4, 32'h10, 32'h0);
        expect_err("st_f3_4");

        // Reset arrives while the store sits in WRITE.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0; reset = 1'b1;
        bad_we = 0; bad_rsp = 0;
        repeat (2) begin
            @(negedge clk);
            bad_we  += int'(mem_we);
            bad_rsp += int'(rsp_valid);
        end
        check("rst_mid_a", mem_a, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        bad_we  += int'(mem_we);
        bad_rsp += int'(rsp_valid);
        repeat (3) begin
            @(negedge clk);
            bad_we  += int'(mem_we);
            bad_rsp += int'(rsp_valid);
        end
        check("rst_mid_no_we", 32'(bad_we), 32'd0);
        check("rst_mid_no_rsp", 32'(bad_rsp), 32'd0);
        check("rst_mid_mem20", tmem[8], 32'hCAFEF00D);

        access(1'b0, F3_W, 32'h20, 32'h0);
        expect_load("lw20", 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
